// File: rtl/tlc_pkg.sv
// ============================================================================
// tlc_pkg
// Shared definitions for the two-road traffic light controller and its
// pedestrian push-button front end.
//   - color_t     : light colour codes driven on rA / rB
//   - ped_state_t : one-hot pedestrian FSM states
//   - TMR_W       : timer width shared with the controller's walk timer
// ============================================================================
package tlc_pkg;

    localparam int TMR_W = 3;

    typedef enum logic [1:0] {
        RED = 2'b00,
        YEL = 2'b01,
        GRN = 2'b10
    } color_t;

    typedef enum logic [2:0] {
        PED_IDLE = 3'b001,
        PED_REQ  = 3'b010,
        PED_WALK = 3'b100
    } ped_state_t;

endpackage

// File: rtl/ped_debounce.sv
// ============================================================================
// ped_debounce
// Synchronises the asynchronous push-button, debounces it and emits a
// one-cycle pulse on each accepted press (rising edge of the debounced level).
// Ports:
//   clk     in  1  clock, rising edge
//   rst_n   in  1  asynchronous active-low reset
//   btn_raw in  1  raw button, asynchronous to clk
//   btn_db  out 1  debounced button level
//   press   out 1  one-cycle pulse when btn_db rises
// ============================================================================
module ped_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_db,
    output logic press
);

    logic [1:0] sync_reg;
    logic       btn_s;
    logic [3:0] cnt_reg;
    logic       btn_db_reg;
    logic       btn_db_prev_reg;

    assign btn_s = sync_reg[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg        <= 2'b00;
            cnt_reg         <= 4'd0;
            btn_db_reg      <= 1'b0;
            btn_db_prev_reg <= 1'b0;
        end else begin
            sync_reg        <= {sync_reg[0], btn_raw};
            btn_db_prev_reg <= btn_db_reg;
            if (btn_s != btn_db_reg) begin
                // Accept the new level on the sample that completes the
                // required run of stable samples.
                if (cnt_reg + 4'd1 == 4'(DEBOUNCE_CYC)) begin
                    btn_db_reg <= btn_s;
                    cnt_reg    <= 4'd0;
                end else begin
                    cnt_reg <= cnt_reg + 4'd1;
                end
            end else begin
                cnt_reg <= 4'd0;
            end
        end
    end

    assign btn_db = btn_db_reg;
    // Decoded from registers only; releases produce no pulse.
    assign press  = btn_db_reg & ~btn_db_prev_reg;

endmodule

// File: rtl/ped_button_ctrl.sv
// ============================================================================
// ped_button_ctrl
// Pedestrian push-button front end. Debounces the crossing button, raises
// ped_req toward the light controller until the all-red walk phase is seen,
// then drives the WALK / DON'T WALK lamps and a countdown display.
// Optional feature macro: PED_FLASH_EN -- when defined, the last FLASH_CYC
// walk cycles turn WALK off and flash DON'T WALK.
// Ports:
//   clk        in  1  clock, rising edge
//   rst_n      in  1  asynchronous active-low reset
//   btn_raw    in  1  raw push-button, asynchronous, active-high
//   rA, rB     in  2  road light codes from the controller
//   ped_req    out 1  registered crossing request
//   walk       out 1  WALK lamp (registered)
//   dont_walk  out 1  DON'T WALK lamp (registered)
//   walk_count out 3  remaining walk cycles (registered)
// ============================================================================
module ped_button_ctrl
    import tlc_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int WALK_CYC     = 4,
    parameter int FLASH_CYC    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_raw,
    input  logic [1:0]       rA,
    input  logic [1:0]       rB,
    output logic             ped_req,
    output logic             walk,
    output logic             dont_walk,
    output logic [TMR_W-1:0] walk_count
);

    localparam logic [TMR_W-1:0] WALK_LEN = TMR_W'(WALK_CYC);

    ped_state_t       state_reg;
    logic [TMR_W-1:0] walk_cnt_reg;
    logic [TMR_W-1:0] cnt_inc;
    logic             ped_req_reg;
    logic             walk_reg;
    logic             dont_walk_reg;
    logic [TMR_W-1:0] walk_count_reg;
    logic             btn_db;
    logic             press;
    logic             all_red;

    ped_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_raw),
        .btn_db  (btn_db),
        .press   (press)
    );

    assign all_red = (rA == RED) && (rB == RED);

    // Saturating walk counter step; saturation keeps walk_count clamped at 0
    // when the controller holds all-red longer than WALK_CYC.
    always_comb begin
        cnt_inc = walk_cnt_reg;
        if (walk_cnt_reg != WALK_LEN) begin
            cnt_inc = walk_cnt_reg + 3'd1;
        end
    end

`ifdef PED_FLASH_EN
    localparam logic [TMR_W-1:0] FLASH_START = TMR_W'(WALK_CYC - FLASH_CYC);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= PED_IDLE;
            walk_cnt_reg   <= '0;
            ped_req_reg    <= 1'b0;
            walk_reg       <= 1'b0;
            dont_walk_reg  <= 1'b1;
            walk_count_reg <= '0;
        end else begin
            case (state_reg)
                PED_IDLE: begin
                    if (press) begin
                        state_reg   <= PED_REQ;
                        ped_req_reg <= 1'b1;
                    end
                end
                PED_REQ: begin
                    if (all_red) begin
                        state_reg      <= PED_WALK;
                        walk_cnt_reg   <= '0;
                        ped_req_reg    <= 1'b0;
                        walk_reg       <= 1'b1;
                        dont_walk_reg  <= 1'b0;
                        walk_count_reg <= WALK_LEN;
                    end
                end
                PED_WALK: begin
                    // Only the lights end the walk phase; presses are ignored.
                    if (!all_red) begin
                        state_reg      <= PED_IDLE;
                        walk_cnt_reg   <= '0;
                        walk_reg       <= 1'b0;
                        dont_walk_reg  <= 1'b1;
                        walk_count_reg <= '0;
                    end else begin
                        walk_cnt_reg   <= cnt_inc;
                        walk_count_reg <= WALK_LEN - cnt_inc;
`ifdef PED_FLASH_EN
                        if (cnt_inc >= FLASH_START) begin
                            walk_reg <= 1'b0;
                            // First flash cycle (WALK still lit) shows 1.
                            dont_walk_reg <= walk_reg ? 1'b1 : ~dont_walk_reg;
                        end
`endif
                    end
                end
                default: begin
                    state_reg      <= PED_IDLE;
                    walk_cnt_reg   <= '0;
                    ped_req_reg    <= 1'b0;
                    walk_reg       <= 1'b0;
                    dont_walk_reg  <= 1'b1;
                    walk_count_reg <= '0;
                end
            endcase
        end
    end

    assign ped_req    = ped_req_reg;
    assign walk       = walk_reg;
    assign dont_walk  = dont_walk_reg;
    assign walk_count = walk_count_reg;

endmodule
